// File: rtl/plus_seq.sv
// Beat sequencer for the zonotope Minkowski sum Z plus W: walks center, G, A and b of OUT.
// Optional: PLUS_SEQ_SKIP_ZERO_EN drops the all-zero off-diagonal blocks of the CON phase.
module plus_seq #(
    parameter int NMAX  = 512,
    parameter int NGMAX = 1024,
    parameter int NCMAX = 512,
    localparam int NW   = $clog2(NMAX) + 1,
    localparam int GW   = $clog2(NGMAX) + 1,
    localparam int CCW  = $clog2(NCMAX) + 1,
    localparam int IW   = $clog2(2 * NGMAX) + 1
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic           start_i,
    input  logic [NW-1:0]  nz_i,
    input  logic [NW-1:0]  nw_i,
    input  logic [GW-1:0]  ngz_i,
    input  logic [GW-1:0]  ngw_i,
    input  logic [CCW-1:0] ncz_i,
    input  logic [CCW-1:0] ncw_i,
    output logic           vld_o,
    input  logic           rdy_i,
    output logic [1:0]     phase_o,
    output logic [IW-1:0]  row_o,
    output logic [IW-1:0]  col_o,
    output logic [1:0]     src_o,
    output logic [IW-1:0]  srow_o,
    output logic [IW-1:0]  scol_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o,
    output logic [2:0]     state_o
);

    localparam int MW0 = (NW > GW) ? NW : GW;
    localparam int MW  = (MW0 > CCW) ? MW0 : CCW;
    localparam int CW  = MW + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    localparam logic [1:0] SRC_ZERO = 2'b00;
    localparam logic [1:0] SRC_Z    = 2'b01;
    localparam logic [1:0] SRC_W    = 2'b10;
    localparam logic [1:0] SRC_ADD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CEN  = 3'd1,
        S_GEN  = 3'd2,
        S_CON  = 3'd3,
        S_BVEC = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   row_q, col_q, row_d, col_d;
    logic [CW-1:0]   n_q, ngz_q, ngw_q, ncz_q, ncw_q;
    logic            err_q;

    // Dimensions seen by the phase logic: live inputs while idle, latched copies afterwards.
    logic [CW-1:0]   d_n, d_ngz, d_ngw, d_ncz, d_ncw, d_ngt, d_nct;
    logic            cen_ne, gen_ne, con_ne, bvec_ne;
    state_t          after_cen, after_gen, after_con, first_ph, nxt_ph;
    logic [CW-1:0]   con_r0, con_c0;

    always_comb begin
        d_n   = (state_q == S_IDLE) ? CW'(nz_i)  : n_q;
        d_ngz = (state_q == S_IDLE) ? CW'(ngz_i) : ngz_q;
        d_ngw = (state_q == S_IDLE) ? CW'(ngw_i) : ngw_q;
        d_ncz = (state_q == S_IDLE) ? CW'(ncz_i) : ncz_q;
        d_ncw = (state_q == S_IDLE) ? CW'(ncw_i) : ncw_q;
        d_ngt = d_ngz + d_ngw;
        d_nct = d_ncz + d_ncw;

        cen_ne  = (d_n != '0);
        gen_ne  = (d_n != '0) && (d_ngt != '0);
        bvec_ne = (d_nct != '0);
`ifdef PLUS_SEQ_SKIP_ZERO_EN
        con_ne  = ((d_ncz != '0) && (d_ngz != '0)) || ((d_ncw != '0) && (d_ngw != '0));
        con_r0  = ((d_ncz != '0) && (d_ngz != '0)) ? '0 : d_ncz;
        con_c0  = ((d_ncz != '0) && (d_ngz != '0)) ? '0 : d_ngz;
`else
        con_ne  = (d_nct != '0) && (d_ngt != '0);
        con_r0  = '0;
        con_c0  = '0;
`endif
        after_con = bvec_ne ? S_BVEC : S_DONE;
        after_gen = con_ne  ? S_CON  : after_con;
        after_cen = gen_ne  ? S_GEN  : after_gen;
        first_ph  = cen_ne  ? S_CEN  : after_cen;
    end

    // Beat fields are a pure function of the registered state and indices, so they
    // cannot change while a beat waits for rdy_i.
    logic [1:0]    phase_c, src_c;
    logic [CW-1:0] srow_c, scol_c, ocol_c;

    always_comb begin
        vld_o   = 1'b0;
        phase_c = 2'b00;
        src_c   = SRC_ZERO;
        srow_c  = '0;
        scol_c  = '0;
        ocol_c  = '0;
        unique case (state_q)
            S_CEN: begin
                vld_o   = 1'b1;
                src_c   = SRC_ADD;
                srow_c  = row_q;
            end
            S_GEN: begin
                vld_o   = 1'b1;
                phase_c = 2'b01;
                ocol_c  = col_q;
                srow_c  = row_q;
                if (col_q < d_ngz) begin
                    src_c  = SRC_Z;
                    scol_c = col_q;
                end else begin
                    src_c  = SRC_W;
                    scol_c = col_q - d_ngz;
                end
            end
            S_CON: begin
                vld_o   = 1'b1;
                phase_c = 2'b10;
                ocol_c  = col_q;
                if ((row_q < d_ncz) && (col_q < d_ngz)) begin
                    src_c  = SRC_Z;
                    srow_c = row_q;
                    scol_c = col_q;
                end else if ((row_q >= d_ncz) && (col_q >= d_ngz)) begin
                    src_c  = SRC_W;
                    srow_c = row_q - d_ncz;
                    scol_c = col_q - d_ngz;
                end
            end
            S_BVEC: begin
                vld_o   = 1'b1;
                phase_c = 2'b11;
                if (row_q < d_ncz) begin
                    src_c  = SRC_Z;
                    srow_c = row_q;
                end else begin
                    src_c  = SRC_W;
                    srow_c = row_q - d_ncz;
                end
            end
            default: ;
        endcase
    end

    assign phase_o = phase_c;
    assign src_o   = src_c;
    assign row_o   = vld_o ? row_q[IW-1:0] : '0;
    assign col_o   = ocol_c[IW-1:0];
    assign srow_o  = srow_c[IW-1:0];
    assign scol_o  = scol_c[IW-1:0];
    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = (state_q == S_DONE);
    assign err_o   = (state_q == S_DONE) && err_q;
    assign state_o = state_q;

    // Index advance within the current phase (column-fastest); last marks the final beat.
    logic [CW-1:0] rows, cols, adv_row, adv_col;
    logic          last;

    always_comb begin
        rows    = ONE;
        cols    = ONE;
        adv_row = row_q;
        adv_col = col_q;
        last    = 1'b0;
        unique case (state_q)
            S_CEN:   begin rows = d_n;   cols = ONE;   end
            S_GEN:   begin rows = d_n;   cols = d_ngt; end
            S_CON:   begin rows = d_nct; cols = d_ngt; end
            S_BVEC:  begin rows = d_nct; cols = ONE;   end
            default: ;
        endcase
        if (col_q + ONE != cols) begin
            adv_col = col_q + ONE;
        end else if (row_q + ONE != rows) begin
            adv_row = row_q + ONE;
            adv_col = '0;
        end else begin
            last = 1'b1;
        end
`ifdef PLUS_SEQ_SKIP_ZERO_EN
        if (state_q == S_CON) begin
            last    = 1'b0;
            adv_row = row_q;
            adv_col = col_q;
            if (row_q < d_ncz) begin
                if (col_q + ONE != d_ngz) begin
                    adv_col = col_q + ONE;
                end else if (row_q + ONE != d_ncz) begin
                    adv_row = row_q + ONE;
                    adv_col = '0;
                end else if ((d_ncw != '0) && (d_ngw != '0)) begin
                    adv_row = d_ncz;
                    adv_col = d_ngz;
                end else begin
                    last = 1'b1;
                end
            end else begin
                if (col_q + ONE != d_ngt) begin
                    adv_col = col_q + ONE;
                end else if (row_q + ONE != d_nct) begin
                    adv_row = row_q + ONE;
                    adv_col = d_ngz;
                end else begin
                    last = 1'b1;
                end
            end
        end
`endif
    end

    // Handshake: a beat transfers on a rising edge where vld_o and rdy_i are both high;
    // indices and phase move only on such a transfer.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        nxt_ph  = S_DONE;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    nxt_ph  = (nz_i != nw_i) ? S_DONE : first_ph;
                    state_d = nxt_ph;
                end
            end
            S_CEN, S_GEN, S_CON, S_BVEC: begin
                if (rdy_i) begin
                    if (last) begin
                        nxt_ph  = (state_q == S_CEN) ? after_cen :
                                  (state_q == S_GEN) ? after_gen :
                                  (state_q == S_CON) ? after_con : S_DONE;
                        state_d = nxt_ph;
                    end else begin
                        row_d = adv_row;
                        col_d = adv_col;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) begin
            row_d = (state_d == S_CON) ? con_r0 : '0;
            col_d = (state_d == S_CON) ? con_c0 : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            n_q     <= '0;
            ngz_q   <= '0;
            ngw_q   <= '0;
            ncz_q   <= '0;
            ncw_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            if ((state_q == S_IDLE) && start_i) begin
                n_q   <= CW'(nz_i);
                ngz_q <= CW'(ngz_i);
                ngw_q <= CW'(ngw_i);
                ncz_q <= CW'(ncz_i);
                ncw_q <= CW'(ncw_i);
                err_q <= (nz_i != nw_i);
            end
        end
    end

endmodule
